// File: rtl/pwm_capture.sv
// pwm_capture: measures an asynchronous PWM input in clk cycles.
// Synchronizes the input, decodes edges and reports the last complete period
// (rise to rise) and its high time, with a one-cycle valid strobe. A missing
// rise for 2^CNT_W-1 cycles raises stuck_o instead of producing a measurement.
//
// Ports:
//   clk      - clock, all state on rising edge
//   res_ni   - asynchronous active-low reset
//   pwm_i    - PWM input, asynchronous to clk
//   en_i     - capture enable (synchronous)
//   period_o - last measured period in cycles
//   high_o   - high time of that period in cycles
//   valid_o  - one-cycle strobe for new period_o/high_o
//   stuck_o  - no rising edge within the counter range (level)
//   level_o  - synchronized input level
module pwm_capture #(
  parameter int unsigned CNT_W = 9
) (
  input  logic             clk,
  input  logic             res_ni,
  input  logic             pwm_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             stuck_o,
  output logic             level_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitLow,
    StWaitRise,
    StMeas,
    StStall
  } state_e;

  logic             r_pwm_m, r_pwm_s, r_pwm_d;
  logic [1:0]       r_sync_fill;
  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_high_lat, w_high_lat_nxt;
  logic [CNT_W-1:0] r_period, w_period_nxt;
  logic [CNT_W-1:0] r_high, w_high_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_stuck, w_stuck_nxt;

  logic w_rise, w_fall, w_sync_full;

  assign w_rise      = r_pwm_s & ~r_pwm_d;
  assign w_fall      = ~r_pwm_s & r_pwm_d;
  // The synchronizer comes out of reset holding 0; a low level on r_pwm_s is only
  // trusted once real samples have propagated through both stages, otherwise an
  // input already high at reset release would look like a genuine rise.
  assign w_sync_full = r_sync_fill[1];

  always_ff @(posedge clk or negedge res_ni) begin
    if (!res_ni) begin
      r_pwm_m     <= 1'b0;
      r_pwm_s     <= 1'b0;
      r_pwm_d     <= 1'b0;
      r_sync_fill <= 2'b00;
    end else begin
      r_pwm_m     <= pwm_i;
      r_pwm_s     <= r_pwm_m;
      r_pwm_d     <= r_pwm_s;
      r_sync_fill <= {r_sync_fill[0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge res_ni) begin
    if (!res_ni) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_high_lat <= '0;
      r_period   <= '0;
      r_high     <= '0;
      r_valid    <= 1'b0;
      r_stuck    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_high_lat <= w_high_lat_nxt;
      r_period   <= w_period_nxt;
      r_high     <= w_high_nxt;
      r_valid    <= w_valid_nxt;
      r_stuck    <= w_stuck_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_high_lat_nxt = r_high_lat;
    w_period_nxt   = r_period;
    w_high_nxt     = r_high;
    w_valid_nxt    = 1'b0;
    w_stuck_nxt    = r_stuck;

    if (!en_i) begin
      // Disable wins over any simultaneous rise: no strobe, measurements hold.
      w_state_nxt = StIdle;
      w_cnt_nxt   = '0;
      w_stuck_nxt = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_state_nxt = StWaitLow;
          w_cnt_nxt   = '0;
          w_stuck_nxt = 1'b0;
        end
        StWaitLow: begin
          if (!r_pwm_s && w_sync_full) w_state_nxt = StWaitRise;
        end
        StWaitRise: begin
          if (w_rise) begin
            w_state_nxt = StMeas;
            w_cnt_nxt   = CntOne;
          end
        end
        StMeas: begin
          if (w_fall) w_high_lat_nxt = r_cnt;
          if (w_rise) begin
            // A rise exactly at CntMax is still a valid full-range period.
            w_period_nxt = r_cnt;
            w_high_nxt   = r_high_lat;
            w_valid_nxt  = 1'b1;
            w_cnt_nxt    = CntOne;
          end else if (r_cnt == CntMax) begin
            w_state_nxt = StStall;
            w_stuck_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CntOne;
          end
        end
        StStall: begin
          // Period across a stall is unknown, so restart without a strobe.
          if (w_rise) begin
            w_state_nxt = StMeas;
            w_cnt_nxt   = CntOne;
            w_stuck_nxt = 1'b0;
          end
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  assign period_o = r_period;
  assign high_o   = r_high;
  assign valid_o  = r_valid;
  assign stuck_o  = r_stuck;
  assign level_o  = r_pwm_s;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: expected measurements are queued when the
// completing rise is driven and popped when valid_o strobes.
module tb_pwm_capture;

  localparam int CntW = 9;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            pwm_i;
  logic            en_i;
  logic [CntW-1:0] period_o;
  logic [CntW-1:0] high_o;
  logic            valid_o;
  logic            stuck_o;
  logic            level_o;

  pwm_capture #(.CNT_W(CntW)) u_dut (
    .clk     (clk),
    .res_ni  (rst_n),
    .pwm_i   (pwm_i),
    .en_i    (en_i),
    .period_o(period_o),
    .high_o  (high_o),
    .valid_o (valid_o),
    .stuck_o (stuck_o),
    .level_o (level_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int period;
    int high;
    int cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   last_h = 0;
  int   last_l = 0;
  int   rise_cyc = 0;
  int   stuck_rise_cyc = -1;
  int   stuck_fall_cyc = -1;
  int   n_stuck_rise = 0;
  logic prev_stuck = 1'b0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Strobe monitor and stuck_o edge recorder, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (valid_o) begin
      if (sb_q.size() == 0) begin
        check_val("spurious_strobe", int'(valid_o), 0);
      end else begin
        e = sb_q.pop_front();
        check_val("period", int'(period_o), e.period);
        check_val("high", int'(high_o), e.high);
        check_val("strobe_cycle", cyc, e.cyc);
      end
    end
    if (stuck_o && !prev_stuck) begin
      n_stuck_rise   <= n_stuck_rise + 1;
      stuck_rise_cyc <= cyc;
    end
    if (!stuck_o && prev_stuck) stuck_fall_cyc <= cyc;
    prev_stuck <= stuck_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the period completed by the rise being driven now; strobe 3 edges later.
  task automatic push_prev();
    sb_q.push_back('{last_h + last_l, last_h, cyc + 3});
  endtask

  // Called just after an edge: drives one period of h high / l low cycles.
  task automatic run_period(input int h, input int l, input bit push);
    pwm_i = 1'b1;
    if (push) push_prev();
    rise_cyc = cyc;
    last_h   = h;
    last_l   = l;
    repeat (h) tick();
    pwm_i = 1'b0;
    repeat (l) tick();
  endtask

  int stall_ref;

  initial begin
    rst_n = 1'b0;
    pwm_i = 1'b0;
    en_i  = 1'b0;

    // Reset with inputs toggling, then release while disabled.
    for (int i = 0; i < 8; i++) begin
      tick();
      pwm_i = 1'($urandom_range(0, 1));
      en_i  = 1'($urandom_range(0, 1));
    end
    check_val("rst_outputs", int'({period_o, high_o, valid_o, stuck_o, level_o}), 0);
    tick();
    en_i  = 1'b0;
    pwm_i = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      pwm_i = (i % 3 == 0);
    end
    check_val("dis_period", int'(period_o), 0);
    check_val("dis_high", int'(high_o), 0);
    check_val("dis_stuck", int'(stuck_o), 0);

    // Steady 3/7 PWM.
    pwm_i = 1'b0;
    en_i  = 1'b1;
    repeat (4) tick();
    run_period(3, 7, 1'b0);
    repeat (6) run_period(3, 7, 1'b1);
    en_i  = 1'b0;
    repeat (6) tick();
    check_val("steady_sb_empty", sb_q.size(), 0);
    check_val("hold_period", int'(period_o), 10);
    check_val("hold_high", int'(high_o), 3);

    // Input high through reset release.
    rst_n = 1'b0;
    pwm_i = 1'b1;
    en_i  = 1'b1;
    #1;
    check_val("rst_async_period", int'(period_o), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check_val("hi_rel_level", int'(level_o), 1);
    pwm_i = 1'b0;
    repeat (6) tick();
    run_period(4, 6, 1'b0);
    run_period(4, 6, 1'b1);
    run_period(4, 6, 1'b1);
    check_val("hi_rel_sb_empty", sb_q.size(), 0);

    // Range edges: full 511-cycle period, then a stall.
    run_period(1, 510, 1'b1);
    run_period(1, 510, 1'b1);
    check_val("no_stuck_511", n_stuck_rise, 0);
    run_period(1, 600, 1'b1);
    stall_ref = rise_cyc;
    check_val("stuck_set", int'(stuck_o), 1);
    check_val("stuck_rises", n_stuck_rise, 1);
    check_val("stuck_time", stuck_rise_cyc, stall_ref + 514);
    run_period(2, 8, 1'b0);
    check_val("stuck_clear", int'(stuck_o), 0);
    check_val("stuck_clr_time", stuck_fall_cyc, rise_cyc + 3);
    run_period(2, 8, 1'b1);

    // Enable abort mid-period.
    pwm_i = 1'b1;
    push_prev();
    last_h = 2;
    last_l = 8;
    repeat (2) tick();
    pwm_i = 1'b0;
    repeat (3) tick();
    en_i = 1'b0;
    tick();
    en_i = 1'b1;
    check_val("abort_hold_period", int'(period_o), 10);
    check_val("abort_hold_high", int'(high_o), 2);
    repeat (4) tick();
    run_period(3, 7, 1'b0);
    run_period(3, 7, 1'b1);

    // Async reset between a fall and a rise.
    pwm_i = 1'b1;
    push_prev();
    last_h = 3;
    last_l = 7;
    repeat (3) tick();
    pwm_i = 1'b0;
    repeat (3) tick();
    check_val("pre_rst_period", int'(period_o), 10);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_outputs", int'({period_o, high_o, valid_o, stuck_o, level_o}), 0);
    check_val("mid_rst_sb_empty", sb_q.size(), 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    run_period(3, 7, 1'b0);
    run_period(3, 7, 1'b1);
    run_period(3, 7, 1'b1);
    en_i = 1'b0;
    repeat (6) tick();
    check_val("final_sb_empty", sb_q.size(), 0);
    check_val("final_period", int'(period_o), 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform: synchronizes it to `clk`, detects edges and reports period and high time in `clk` cycles, with a one-cycle valid strobe per completed period. It is the receive-side counterpart to the team's set/clear/reload PWM generator. It is used for loop-back checking of generated PWM and for decoding external PWM inputs. A stalled input (no rising edge within the counter range) is flagged instead of producing a measurement.

## Interface
- `CNT_W`, default 9: width of the cycle counter and of the measurement outputs. The maximum measurable period is 2^CNT_W−1, which is 511 by default and covers the generator's full 8-bit reload range.

- `clk` in 1: the only clock; all state changes on its rising edge.
- `res_ni` in 1: reset, asynchronous, active-low.
- `pwm_i` in 1: PWM input, asynchronous to `clk`.
- `en_i` in 1: capture enable, synchronous.
- `period_o` out CNT_W: last measured period, rising edge to rising edge, in cycles.
- `high_o` out CNT_W: high time of that same period, in cycles.
- `valid_o` out 1: one-cycle strobe marking new `period_o`/`high_o` values.
- `stuck_o` out 1: no rising edge for 2^CNT_W−1 cycles; level-valued.
- `level_o` out 1: synchronized input level (`pwm_s`).

## Operation
- **Synchronizer:** two flops `pwm_i` → `pwm_m` → `pwm_s`, then a delay flop `pwm_d`. All three reset to 0.
  - rise = `pwm_s` & ~`pwm_d`.
  - fall = ~`pwm_s` & `pwm_d`.
- **FSM states:** IDLE, WAIT_LOW, WAIT_RISE, MEAS, STALL. Reset state is IDLE.
- **`en_i` = 0:** from any state, the next state is IDLE. In IDLE: `cnt` = 0, `valid_o` = 0, `stuck_o` = 0; `period_o` and `high_o` hold their values.
- **IDLE → WAIT_LOW** when `en_i` = 1.
- **WAIT_LOW → WAIT_RISE** when `pwm_s` = 0. This blocks a false rise caused by the reset-zero synchronizer while the input is already high.
- **WAIT_RISE → MEAS** on rise: `cnt` ← 1, no strobe.
- **MEAS, every cycle:** `cnt` ← `cnt`+1. Inside the period, `cnt` equals the number of cycles since the starting rise.
  - **On fall:** `high_lat` ← `cnt`.
  - **On rise:** `period_o` ← `cnt`, `high_o` ← `high_lat`, `valid_o` ← 1, `cnt` ← 1.
  - **`cnt` = 2^CNT_W−1 with no rise:** go to STALL, `stuck_o` ← 1, no strobe.
- **STALL:** `cnt` holds. On rise: MEAS, `cnt` ← 1, `stuck_o` ← 0, no strobe, because the period is unknown.
- **Invariants:**
  - `high_o` ≤ `period_o` − 1 whenever `valid_o` has ever pulsed, since the input must fall between two rises.
  - `cnt` never wraps.
- **Simultaneous events:**
  - Rise and fall cannot coexist.
  - Rise in the same cycle as `cnt` = MAX is a valid period of 2^CNT_W−1, not a stall.
  - If `en_i` falls in the same cycle as a rise, the disable wins: no strobe.
- **Reset mid-operation:**
  - All flops clear immediately: outputs 0, state IDLE.
  - No `valid_o` until two genuine rises are seen after release.

## Timing
- **Synchronizer latency:** a `pwm_i` transition first appears on `pwm_s` after 2 clock edges. Rise/fall is decoded during the following cycle, and the registered results appear after the 3rd edge.
- **Strobe latency:** `valid_o`, `period_o` and `high_o` update together on the 3rd clock edge after the `pwm_i` rising edge. `valid_o` is high for exactly one cycle.
- **`stuck_o` timing:**
  - Rises on the edge after the cycle in which `cnt` = 2^CNT_W−1, which is 2^CNT_W cycles after the last rise is decoded.
  - Clears on the edge that decodes the next rise.
- **First strobe:** the first `valid_o` after enable comes at the second decoded rise.
- **Rate limit:** the minimum decodable high or low phase is 1 cycle, so the minimum period is 2. Input phases shorter than 1 `clk` period may be missed.
- **Registering:** all outputs are registered. No combinational path runs from inputs to outputs.

## Test plan
- **Reset:** assert `res_ni` = 0 with inputs toggling → all outputs 0. Release with `en_i` = 0 → outputs stay 0 and there are no strobes.
- **Steady PWM:** `en_i` = 1; `pwm_i` repeats high 3 / low 7 cycles, matching the generator with reload = 9, set = 0, clr = 3.
  - The first `valid_o` comes 3 edges after the 2nd rise, with `period_o` = 10 and `high_o` = 3.
  - Further strobes come every 10 cycles, all with identical values.
- **High at reset release:** hold `pwm_i` = 1 through reset release with `en_i` = 1, then run 4/6 cycles → no strobe until the first genuine rise plus one full period. Then `period_o` = 10, `high_o` = 4.
- **Range edges:**
  - High 1 / low 510 → `period_o` = 511, `high_o` = 1, `stuck_o` stays 0.
  - Low held for 600 cycles → `stuck_o` = 1 exactly 512 cycles after the last decoded rise, with no strobe.
  - The next rise clears `stuck_o`. The following rise strobes the correct period.
- **Enable abort:** drop `en_i` for 1 cycle mid-period → no strobe for the aborted period and outputs hold. Capture then re-arms through WAIT_LOW; the first strobe comes after two new rises.
- **Async reset mid-measurement:** pulse `res_ni` low between a fall and a rise → outputs are 0 immediately, without waiting for a clock edge. The next strobe needs two post-reset rises.
